// File: rtl/assoc_btb.sv
// assoc_btb: fully associative branch target buffer with saturating direction counters and true-LRU replacement.
// Define ASSOC_BTB_PERF_EN to add the perf_lookups / perf_hits counters.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif

module assoc_btb #(
    parameter int ADDR_W  = `IM_ADDR_BIT,
    parameter int ENTRIES = 8,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] lookup_pc_4,
    output logic              pred_hit,
    output logic [CTR_W-1:0]  pred_ctr,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_pc_4,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_taken
`ifdef ASSOC_BTB_PERF_EN
    ,
    output logic [31:0]       perf_lookups,
    output logic [31:0]       perf_hits
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [IDX_W-1:0] AGE_OLDEST = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid_reg;
    logic [ADDR_W-1:0]  tag_reg    [ENTRIES];
    logic [ADDR_W-1:0]  target_reg [ENTRIES];
    logic [CTR_W-1:0]   ctr_reg    [ENTRIES];
    logic [IDX_W-1:0]   age_reg    [ENTRIES];

    logic [ENTRIES-1:0] lk_match;
    logic [ENTRIES-1:0] up_match;
    logic [ADDR_W-1:0]  lk_target_masked [ENTRIES];
    logic [CTR_W-1:0]   lk_ctr_masked    [ENTRIES];
    logic [CTR_W-1:0]   up_ctr_masked    [ENTRIES];
    logic [IDX_W-1:0]   up_idx_masked    [ENTRIES];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign lk_match[gi]         = valid_reg[gi] && (tag_reg[gi] == lookup_pc_4);
            assign up_match[gi]         = valid_reg[gi] && (tag_reg[gi] == update_pc_4);
            assign lk_target_masked[gi] = lk_match[gi] ? target_reg[gi] : '0;
            assign lk_ctr_masked[gi]    = lk_match[gi] ? ctr_reg[gi] : '0;
            assign up_ctr_masked[gi]    = up_match[gi] ? ctr_reg[gi] : '0;
            assign up_idx_masked[gi]    = up_match[gi] ? IDX_W'(gi) : '0;
        end
    endgenerate

    // At most one entry matches a tag, so OR-reducing the masked fields selects it.
    logic [ADDR_W-1:0] hit_target;
    logic [CTR_W-1:0]  hit_ctr;
    logic [CTR_W-1:0]  up_ctr;
    logic [IDX_W-1:0]  up_idx;

    always_comb begin
        hit_target = '0;
        hit_ctr    = '0;
        up_ctr     = '0;
        up_idx     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_target = hit_target | lk_target_masked[i];
            hit_ctr    = hit_ctr | lk_ctr_masked[i];
            up_ctr     = up_ctr | up_ctr_masked[i];
            up_idx     = up_idx | up_idx_masked[i];
        end
    end

    logic pred_taken;
    assign pred_hit    = |lk_match;
    assign pred_ctr    = hit_ctr;
    assign pred_taken  = pred_hit && hit_ctr[CTR_W-1];
    assign pred_target = pred_taken ? hit_target : lookup_pc_4;

    // Victim: lowest-index invalid entry, otherwise the least recently used one.
    logic [IDX_W-1:0] victim_idx;
    logic             found_invalid;

    always_comb begin
        victim_idx    = '0;
        found_invalid = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid_reg[i] && !found_invalid) begin
                victim_idx    = IDX_W'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (age_reg[i] == AGE_OLDEST) begin
                    victim_idx = IDX_W'(i);
                end
            end
        end
    end

    logic             up_hit;
    logic             touch_en;
    logic [IDX_W-1:0] touch_idx;
    logic [IDX_W-1:0] touch_age;
    logic [CTR_W-1:0] ctr_next;

    assign up_hit    = |up_match;
    assign touch_en  = update_en && !flush && (up_hit || update_taken);
    assign touch_idx = up_hit ? up_idx : victim_idx;
    assign touch_age = age_reg[touch_idx];

    always_comb begin
        ctr_next = up_ctr;
        if (update_taken) begin
            if (up_ctr != CTR_MAX) ctr_next = up_ctr + CTR_W'(1);
        end else begin
            if (up_ctr != '0) ctr_next = up_ctr - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                ctr_reg[i]    <= '0;
                age_reg[i]    <= IDX_W'(i);
            end
        end else if (flush) begin
            valid_reg <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                age_reg[i] <= IDX_W'(i);
            end
        end else if (touch_en) begin
            // Younger-than-touched entries age by one; the touched entry becomes most recent.
            for (int i = 0; i < ENTRIES; i++) begin
                if (IDX_W'(i) == touch_idx) begin
                    age_reg[i] <= '0;
                end else if (age_reg[i] < touch_age) begin
                    age_reg[i] <= age_reg[i] + IDX_W'(1);
                end
            end
            if (up_hit) begin
                ctr_reg[up_idx] <= ctr_next;
                if (update_taken) target_reg[up_idx] <= update_target;
            end else begin
                valid_reg[victim_idx]  <= 1'b1;
                tag_reg[victim_idx]    <= update_pc_4;
                target_reg[victim_idx] <= update_target;
                ctr_reg[victim_idx]    <= CTR_INIT;
            end
        end
    end

`ifdef ASSOC_BTB_PERF_EN
    logic [31:0] perf_lookups_reg;
    logic [31:0] perf_hits_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lookups_reg <= '0;
            perf_hits_reg    <= '0;
        end else if (flush) begin
            perf_lookups_reg <= '0;
            perf_hits_reg    <= '0;
        end else begin
            perf_lookups_reg <= perf_lookups_reg + 32'd1;
            if (pred_hit) perf_hits_reg <= perf_hits_reg + 32'd1;
        end
    end

    assign perf_lookups = perf_lookups_reg;
    assign perf_hits    = perf_hits_reg;
`endif

endmodule

// File: tb/tb_assoc_btb.sv
// Directed, table-driven bench for assoc_btb (ENTRIES=8, CTR_W=2, ADDR_W=32).
module tb_assoc_btb;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] lookup_pc_4;
    logic        pred_hit;
    logic [1:0]  pred_ctr;
    logic [31:0] pred_target;
    logic        update_en;
    logic [31:0] update_pc_4;
    logic [31:0] update_target;
    logic        update_taken;
`ifdef ASSOC_BTB_PERF_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_hits;
`endif

    int checks   = 0;
    int failures = 0;

    assoc_btb #(.ADDR_W(32), .ENTRIES(8), .CTR_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .lookup_pc_4   (lookup_pc_4),
        .pred_hit      (pred_hit),
        .pred_ctr      (pred_ctr),
        .pred_target   (pred_target),
        .update_en     (update_en),
        .update_pc_4   (update_pc_4),
        .update_target (update_target),
        .update_taken  (update_taken)
`ifdef ASSOC_BTB_PERF_EN
        ,
        .perf_lookups  (perf_lookups),
        .perf_hits     (perf_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utaken;
        logic        fl;
        logic [31:0] lpc;
        logic        ehit;
        logic [1:0]  ectr;
        logic [31:0] etgt;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic upd, input logic [31:0] upc, input logic [31:0] utgt,
                                input logic utaken, input logic fl, input logic [31:0] lpc,
                                input logic ehit, input logic [1:0] ectr, input logic [31:0] etgt);
        vec_t v;
        v.upd = upd; v.upc = upc; v.utgt = utgt; v.utaken = utaken; v.fl = fl;
        v.lpc = lpc; v.ehit = ehit; v.ectr = ectr; v.etgt = etgt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", nm, act);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic upd, input logic [31:0] upc, input logic [31:0] utgt,
                         input logic utaken, input logic fl, input logic [31:0] lpc);
        @(negedge clk);
        update_en     = upd;
        update_pc_4   = upc;
        update_target = utgt;
        update_taken  = utaken;
        flush         = fl;
        lookup_pc_4   = lpc;
        #1;
    endtask

    logic [2:0] exp_age [8];

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        update_en = 1'b0;
        update_pc_4 = '0;
        update_target = '0;
        update_taken = 1'b0;
        lookup_pc_4 = '0;

        //            upd upc     utgt    tk fl lpc     hit ctr tgt
        vecs[0]  = mk(0, 32'h0,   32'h0,   0, 0, 32'h104, 0, 0, 32'h104); // reset state
        vecs[1]  = mk(1, 32'h104, 32'h200, 1, 0, 32'h104, 0, 0, 32'h104); // no bypass
        vecs[2]  = mk(1, 32'h104, 32'h0,   0, 0, 32'h104, 1, 2, 32'h200);
        vecs[3]  = mk(1, 32'h104, 32'h0,   0, 0, 32'h104, 1, 1, 32'h104);
        vecs[4]  = mk(1, 32'h104, 32'h0,   0, 0, 32'h104, 1, 0, 32'h104);
        vecs[5]  = mk(1, 32'h104, 32'h250, 1, 0, 32'h104, 1, 0, 32'h104); // stayed at 0
        vecs[6]  = mk(1, 32'h104, 32'h260, 1, 0, 32'h104, 1, 1, 32'h104);
        vecs[7]  = mk(1, 32'h104, 32'h270, 1, 0, 32'h104, 1, 2, 32'h260);
        vecs[8]  = mk(1, 32'h104, 32'h280, 1, 0, 32'h104, 1, 3, 32'h270);
        vecs[9]  = mk(0, 32'h0,   32'h0,   0, 0, 32'h104, 1, 3, 32'h280); // saturated
        vecs[10] = mk(1, 32'h300, 32'h400, 0, 0, 32'h300, 0, 0, 32'h300);
        vecs[11] = mk(0, 32'h0,   32'h0,   0, 0, 32'h300, 0, 0, 32'h300); // not-taken miss: no alloc
        vecs[12] = mk(0, 32'h0,   32'h0,   0, 1, 32'h104, 1, 3, 32'h280);
        vecs[13] = mk(0, 32'h0,   32'h0,   0, 0, 32'h104, 0, 0, 32'h104); // flushed
        vecs[14] = mk(1, 32'h104, 32'h200, 1, 1, 32'h104, 0, 0, 32'h104); // flush beats update
        vecs[15] = mk(0, 32'h0,   32'h0,   0, 0, 32'h104, 0, 0, 32'h104);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].upd, vecs[i].upc, vecs[i].utgt, vecs[i].utaken, vecs[i].fl, vecs[i].lpc);
            chk($sformatf("vec%0d_hit", i), 32'(pred_hit), 32'(vecs[i].ehit));
            chk($sformatf("vec%0d_ctr", i), 32'(pred_ctr), 32'(vecs[i].ectr));
            chk($sformatf("vec%0d_target", i), pred_target, vecs[i].etgt);
        end

        // LRU: fill 0x10..0x80, touch 0x10, then 0x90 must evict 0x20.
        for (int k = 1; k <= 8; k++) begin
            drive(1, 32'(k * 16), 32'h1000 + 32'(k * 16), 1, 0, 32'h0);
        end
        drive(1, 32'h10, 32'h2010, 1, 0, 32'h0);
        drive(1, 32'h90, 32'h1090, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h20);
        chk("lru_evict_20_hit", 32'(pred_hit), 32'd0);
        drive(0, 0, 0, 0, 0, 32'h10);
        chk("lru_10_hit", 32'(pred_hit), 32'd1);
        chk("lru_10_ctr", 32'(pred_ctr), 32'd3);
        chk("lru_10_target", pred_target, 32'h2010);
        drive(0, 0, 0, 0, 0, 32'h90);
        chk("lru_90_hit", 32'(pred_hit), 32'd1);
        chk("lru_90_target", pred_target, 32'h1090);
        drive(0, 0, 0, 0, 0, 32'h80);
        chk("lru_80_target", pred_target, 32'h1080);

        // Not-taken miss must leave the whole age permutation alone.
        drive(1, 32'h300, 32'h5000, 0, 0, 32'h300);
        drive(0, 0, 0, 0, 0, 32'h300);
        chk("nt_miss_hit", 32'(pred_hit), 32'd0);
        exp_age[0] = 3'd1; exp_age[1] = 3'd0; exp_age[2] = 3'd7; exp_age[3] = 3'd6;
        exp_age[4] = 3'd5; exp_age[5] = 3'd4; exp_age[6] = 3'd3; exp_age[7] = 3'd2;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("age%0d", i), 32'(dut.age_reg[i]), 32'(exp_age[i]));
        end

        // Asynchronous reset clears state between clock edges.
        drive(0, 0, 0, 0, 0, 32'h90);
        chk("pre_reset_hit", 32'(pred_hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_hit", 32'(pred_hit), 32'd0);
        chk("async_reset_target", pred_target, 32'h90);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h90);
        chk("post_reset_hit", 32'(pred_hit), 32'd0);

`ifdef ASSOC_BTB_PERF_EN
        drive(0, 0, 0, 0, 1, 32'h600);
        drive(1, 32'h500, 32'h700, 1, 0, 32'h600);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 0, (i < 4) ? 32'h500 : 32'h600);
        end
        drive(0, 0, 0, 0, 1, 32'h600);
        chk("perf_lookups", perf_lookups, 32'd10);
        chk("perf_hits", perf_hits, 32'd4);
        drive(0, 0, 0, 0, 0, 32'h600);
        chk("perf_lookups_flushed", perf_lookups, 32'd0);
        chk("perf_hits_flushed", perf_hits, 32'd0);
`endif

        drive(0, 0, 0, 0, 0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
